// File: rtl/i4002_bank.sv
// i4002_bank: a bank of 4002-class RAM chips behind one shared MCS-4
// instruction-cycle decoder, plus a debug port that is only granted
// outside the CPU's X1/X2 data phases.
// Optional build macro: I4002_BANK_CLR_EN adds dbg_clr/clr_busy and a
// row-per-clock memory clear sweep.
module i4002_bank #(
    parameter int NUM_BANKS      = 1,
    parameter int CHIPS_PER_BANK = 4,
    parameter int CHIP_BASE      = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  sync,
    input  logic [NUM_BANKS-1:0]                  cm_ram,
    input  logic [3:0]                            dbus_in,
    output logic [3:0]                            dbus_out,
    output logic                                  dbus_oe,
    output logic [NUM_BANKS*CHIPS_PER_BANK*4-1:0] io_out,
    input  logic                                  dbg_req,
    input  logic                                  dbg_we,
    input  logic [8:0]                            dbg_addr,
    input  logic [7:0]                            dbg_wdata,
    output logic                                  dbg_gnt,
    output logic [7:0]                            dbg_rdata,
    output logic                                  dbg_rdata_vld
`ifdef I4002_BANK_CLR_EN
    ,
    input  logic                                  dbg_clr,
    output logic                                  clr_busy
`endif
);

    localparam int NCHIPS = NUM_BANKS * CHIPS_PER_BANK;

    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    // Storage is indexed by slot = {bank, local chip}. Slots outside the
    // configured geometry are never written and stay at zero.
    logic [3:0] mem_reg  [16][4][16];
    logic [3:0] stat_reg [16][4][4];
    logic [3:0] io_reg   [16];

    logic [2:0] phase_reg;
    logic       op_valid_reg;
    logic [3:0] opa_reg;
    logic [1:0] op_bank_reg;
    logic [7:0] src_reg;
    logic [1:0] src_bank_reg;
    logic       src_valid_reg;
    logic [3:0] rd_data_reg;
    logic       rd_en_reg;
    logic [7:0] dbg_rdata_reg;
    logic       dbg_rdata_vld_reg;

    logic       cpu_sel;
    logic [3:0] cpu_slot;
    logic       is_rd_main, is_rd_stat, is_wr_main, is_wr_io, is_wr_stat;
    logic       cpu_wr_en;
    logic [3:0] cpu_rd_data;
    logic       dbg_in_range;
    logic [3:0] dbg_slot;
    logic       dbg_wr_en;

    logic       clr_active;
    logic [3:0] clr_slot;
    logic [1:0] clr_row;

    function automatic logic [1:0] lowest_bank(input logic [NUM_BANKS-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic chip_ok(input logic [1:0] c);
        return (int'(c) >= CHIP_BASE) && (int'(c) < CHIP_BASE + CHIPS_PER_BANK);
    endfunction

    // Instruction-cycle phase counter, restarted by sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       phase_reg <= '0;
        else if (sync) phase_reg <= '0;
        else           phase_reg <= phase_reg + 3'd1;
    end

    // Opcode latch at M2, SRC address latch at X2/X3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_reg  <= 1'b0;
            opa_reg       <= '0;
            op_bank_reg   <= '0;
            src_reg       <= '0;
            src_bank_reg  <= '0;
            src_valid_reg <= 1'b0;
        end else begin
            if (phase_reg == PH_M2) begin
                op_valid_reg <= |cm_ram;
                opa_reg      <= dbus_in;
                op_bank_reg  <= lowest_bank(cm_ram);
            end
            if (phase_reg == PH_X2) begin
                src_valid_reg <= |cm_ram;
                if (|cm_ram) begin
                    src_bank_reg  <= lowest_bank(cm_ram);
                    src_reg[7:4]  <= dbus_in;
                end
            end
            if (phase_reg == PH_X3 && src_valid_reg) src_reg[3:0] <= dbus_in;
        end
    end

    // Chip selection, opcode decode and the CPU read mux.
    always_comb begin
        cpu_sel    = op_valid_reg && (op_bank_reg == src_bank_reg) && chip_ok(src_reg[7:6]);
        cpu_slot   = {op_bank_reg, src_reg[7:6] - 2'(CHIP_BASE)};
        is_rd_main = (opa_reg == 4'h8) || (opa_reg == 4'h9) || (opa_reg == 4'hB);
        is_rd_stat = (opa_reg[3:2] == 2'b11);
        is_wr_main = (opa_reg == 4'h0);
        is_wr_io   = (opa_reg == 4'h1);
        is_wr_stat = (opa_reg[3:2] == 2'b01);
        cpu_wr_en  = (phase_reg == PH_X2) && cpu_sel && !clr_active;
        if (is_rd_stat) cpu_rd_data = stat_reg[cpu_slot][src_reg[5:4]][opa_reg[1:0]];
        else            cpu_rd_data = mem_reg[cpu_slot][src_reg[5:4]][src_reg[3:0]];
    end

    // Debug address decode and grant; the CPU owns the bus in X1/X2.
    always_comb begin
        dbg_in_range = (int'(dbg_addr[8:7]) < NUM_BANKS) && chip_ok(dbg_addr[6:5]);
        dbg_slot     = {dbg_addr[8:7], dbg_addr[6:5] - 2'(CHIP_BASE)};
        dbg_gnt      = dbg_req && !rst && !clr_active
                       && (phase_reg != PH_X1) && (phase_reg != PH_X2);
        dbg_wr_en    = dbg_gnt && dbg_we && dbg_in_range;
    end

    // CPU read data captured at the end of X1 and driven during X2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
            rd_en_reg   <= 1'b0;
        end else if (phase_reg == PH_X1) begin
            rd_en_reg   <= cpu_sel && (is_rd_main || is_rd_stat);
            rd_data_reg <= clr_active ? 4'h0 : cpu_rd_data;
        end
    end

    // Data-bus drive: only in X2 of a selected read.
    always_comb begin
        dbus_oe  = (phase_reg == PH_X2) && rd_en_reg;
        dbus_out = (dbus_oe && !clr_active) ? rd_data_reg : 4'h0;
    end

    // Main and status storage: reset, clear sweep, CPU and debug writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 16; s++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 16; c++) mem_reg[s][r][c] <= '0;
                    for (int c = 0; c < 4; c++)  stat_reg[s][r][c] <= '0;
                end
            end
        end else if (clr_active) begin
            for (int c = 0; c < 16; c++) mem_reg[clr_slot][clr_row][c] <= '0;
            for (int c = 0; c < 4; c++)  stat_reg[clr_slot][clr_row][c] <= '0;
        end else begin
            if (cpu_wr_en && is_wr_main)
                mem_reg[cpu_slot][src_reg[5:4]][src_reg[3:0]] <= dbus_in;
            if (cpu_wr_en && is_wr_stat)
                stat_reg[cpu_slot][src_reg[5:4]][opa_reg[1:0]] <= dbus_in;
            if (dbg_wr_en) begin
                mem_reg[dbg_slot][dbg_addr[4:3]][{dbg_addr[2:0], 1'b0}] <= dbg_wdata[3:0];
                mem_reg[dbg_slot][dbg_addr[4:3]][{dbg_addr[2:0], 1'b1}] <= dbg_wdata[7:4];
            end
        end
    end

    // Per-chip output ports; untouched by the clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 16; s++) io_reg[s] <= '0;
        end else if (cpu_wr_en && is_wr_io) begin
            io_reg[cpu_slot] <= dbus_in;
        end
    end

    generate
        for (genvar gi = 0; gi < NCHIPS; gi++) begin : g_io
            assign io_out[gi*4 +: 4] = io_reg[(gi / CHIPS_PER_BANK) * 4 + (gi % CHIPS_PER_BANK)];
        end
    endgenerate

    // Debug read data on the grant clock, valid strobe one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_rdata_reg     <= '0;
            dbg_rdata_vld_reg <= 1'b0;
        end else begin
            dbg_rdata_vld_reg <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata_reg <= dbg_in_range
                    ? {mem_reg[dbg_slot][dbg_addr[4:3]][{dbg_addr[2:0], 1'b1}],
                       mem_reg[dbg_slot][dbg_addr[4:3]][{dbg_addr[2:0], 1'b0}]}
                    : 8'h00;
            end
        end
    end

    assign dbg_rdata     = dbg_rdata_reg;
    assign dbg_rdata_vld = dbg_rdata_vld_reg;

`ifdef I4002_BANK_CLR_EN
    typedef enum logic [0:0] {CLR_IDLE, CLR_CLEAR} clr_state_t;
    clr_state_t clr_state_reg, clr_state_next;
    logic [1:0] clr_bank_reg, clr_chip_reg, clr_row_reg;
    logic       clr_last;

    // Clear FSM state register and row walker ({bank, chip, reg} order).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state_reg <= CLR_IDLE;
            clr_bank_reg  <= '0;
            clr_chip_reg  <= '0;
            clr_row_reg   <= '0;
        end else begin
            clr_state_reg <= clr_state_next;
            if (clr_state_reg == CLR_CLEAR) begin
                clr_row_reg <= clr_row_reg + 2'd1;
                if (clr_row_reg == 2'd3) begin
                    if (int'(clr_chip_reg) == CHIPS_PER_BANK - 1) begin
                        clr_chip_reg <= '0;
                        clr_bank_reg <= clr_bank_reg + 2'd1;
                    end else begin
                        clr_chip_reg <= clr_chip_reg + 2'd1;
                    end
                end
            end else begin
                clr_bank_reg <= '0;
                clr_chip_reg <= '0;
                clr_row_reg  <= '0;
            end
        end
    end

    // Clear FSM next state; a dbg_clr pulse during a sweep is ignored.
    always_comb begin
        clr_state_next = clr_state_reg;
        clr_last = (clr_row_reg == 2'd3) && (int'(clr_chip_reg) == CHIPS_PER_BANK - 1)
                   && (int'(clr_bank_reg) == NUM_BANKS - 1);
        case (clr_state_reg)
            CLR_IDLE:  if (dbg_clr)  clr_state_next = CLR_CLEAR;
            CLR_CLEAR: if (clr_last) clr_state_next = CLR_IDLE;
            default:                 clr_state_next = CLR_IDLE;
        endcase
    end

    assign clr_active = (clr_state_reg == CLR_CLEAR);
    assign clr_busy   = clr_active;
    assign clr_slot   = {clr_bank_reg, clr_chip_reg};
    assign clr_row    = clr_row_reg;
`else
    assign clr_active = 1'b0;
    assign clr_slot   = 4'h0;
    assign clr_row    = 2'h0;
`endif

endmodule

// File: tb/tb_i4002_bank.sv
// Directed testbench for i4002_bank (two banks of four chips).
module tb_i4002_bank;
    localparam int NB  = 2;
    localparam int CPB = 4;

    logic              clk = 1'b0;
    logic              rst, sync;
    logic [NB-1:0]     cm_ram;
    logic [3:0]        dbus_in, dbus_out;
    logic              dbus_oe;
    logic [NB*CPB*4-1:0] io_out;
    logic              dbg_req, dbg_we, dbg_gnt, dbg_rdata_vld;
    logic [8:0]        dbg_addr;
    logic [7:0]        dbg_wdata, dbg_rdata;
`ifdef I4002_BANK_CLR_EN
    logic              dbg_clr, clr_busy;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i4002_bank #(.NUM_BANKS(NB), .CHIPS_PER_BANK(CPB), .CHIP_BASE(0)) dut (
        .clk(clk), .rst(rst), .sync(sync), .cm_ram(cm_ram),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe), .io_out(io_out),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rdata_vld(dbg_rdata_vld)
`ifdef I4002_BANK_CLR_EN
        , .dbg_clr(dbg_clr), .clr_busy(clr_busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction cycle: sync, then A1..X3 with cm_ram/dbus_in driven
    // in M2, X2 and X3. Records dbus_oe per phase and dbus_out in X2.
    task automatic instr(input logic [NB-1:0] cm_m2, input logic [3:0] d_m2,
                         input logic [NB-1:0] cm_x2, input logic [3:0] d_x2,
                         input logic [3:0] d_x3,
                         output logic [7:0] oe_mask, output logic [3:0] x2_data);
        oe_mask = '0;
        x2_data = '0;
        @(negedge clk);
        sync = 1'b1; cm_ram = '0; dbus_in = '0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            sync    = 1'b0;
            cm_ram  = (p == 4) ? cm_m2 : (p == 6) ? cm_x2 : '0;
            dbus_in = (p == 4) ? d_m2 : (p == 6) ? d_x2 : (p == 7) ? d_x3 : 4'h0;
            #1;
            oe_mask[p] = dbus_oe;
            if (p == 6) x2_data = dbus_out;
        end
        @(negedge clk);
        cm_ram = '0; dbus_in = '0;
    endtask

    // Debug access, bounded wait for the grant.
    task automatic dbg_access(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                              output logic [7:0] rd, output logic granted);
        granted = 1'b0;
        rd = '0;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        repeat (20) begin
            if (!granted) begin
                #1;
                if (dbg_gnt) granted = 1'b1;
                else @(negedge clk);
            end
        end
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 1'b0;
        if (!we) begin
            check("dbg_rdata_vld", 32'(dbg_rdata_vld), 32'h1);
            rd = dbg_rdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] oe_mask, gnt_mask, rd;
        logic [3:0] x2d;
        logic       granted, oe_any;
        int         busy_cnt;

        rst = 1'b1; sync = 1'b0; cm_ram = '0; dbus_in = '0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`ifdef I4002_BANK_CLR_EN
        dbg_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_dbus_out", 32'(dbus_out), 32'h0);
        check("rst_dbus_oe", 32'(dbus_oe), 32'h0);
        check("rst_io_out", io_out, 32'h0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'h0);
        check("rst_dbg_vld", 32'(dbg_rdata_vld), 32'h0);
        @(negedge clk);
        rst = 1'b0; dbg_req = 1'b0;

        // CPU write then read: SRC 0x25 on bank 0, WRM 0xA, RDM.
        instr(2'b00, 4'h0, 2'b01, 4'h2, 4'h5, oe_mask, x2d);
        $display("SRC 0x25 bank0");
        instr(2'b01, 4'h0, 2'b00, 4'hA, 4'h0, oe_mask, x2d);
        $display("WRM 0xA oe_mask=%02h", oe_mask);
        check("wrm_no_oe", 32'(oe_mask), 32'h0);
        instr(2'b01, 4'h9, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RDM oe_mask=%02h data=%h", oe_mask, x2d);
        check("rdm_oe_x2_only", 32'(oe_mask), 32'h40);
        check("rdm_data", 32'(x2d), 32'hA);
        dbg_access(1'b0, 9'h012, 8'h00, rd, granted);
        $display("DBG RD {0,0,2,2} data=%02h", rd);
        check("dbg_rd_gnt", 32'(granted), 32'h1);
        check("dbg_rd_0022", 32'(rd), 32'hA0);

        // Bank select: SRC on bank 1 chip 1, WMP 0x7.
        instr(2'b00, 4'h0, 2'b10, 4'h4, 4'h0, oe_mask, x2d);
        instr(2'b10, 4'h1, 2'b00, 4'h7, 4'h0, oe_mask, x2d);
        $display("WMP bank1 chip1 io_out=%08h", io_out);
        check("wmp_bank1_chip1", io_out, 32'h0070_0000);
        // Both lines at M2: lowest is bank 0, SRC is on bank 1, so no effect.
        instr(2'b11, 4'h1, 2'b00, 4'h3, 4'h0, oe_mask, x2d);
        $display("WMP bank mismatch io_out=%08h", io_out);
        check("wmp_bank_mismatch", io_out, 32'h0070_0000);

        // Status: chip 3 reg 1, WR3 0xC, RD3 and RD2.
        instr(2'b00, 4'h0, 2'b01, 4'hD, 4'h0, oe_mask, x2d);
        instr(2'b01, 4'h7, 2'b00, 4'hC, 4'h0, oe_mask, x2d);
        instr(2'b01, 4'hF, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RD3 oe_mask=%02h data=%h", oe_mask, x2d);
        check("rd3_oe", 32'(oe_mask), 32'h40);
        check("rd3_data", 32'(x2d), 32'hC);
        instr(2'b01, 4'hE, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RD2 oe_mask=%02h data=%h", oe_mask, x2d);
        check("rd2_data", 32'(x2d), 32'h0);

        // Arbitration: request raised in X1 must wait until X3.
        gnt_mask = '0;
        @(negedge clk);
        sync = 1'b1;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            sync = 1'b0;
            if (p == 5) begin
                dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 8'h5A;
            end
            #1;
            gnt_mask[p] = dbg_gnt;
        end
        @(negedge clk);
        dbg_req = 1'b0; dbg_we = 1'b0;
        $display("ARB gnt_mask=%02h", gnt_mask);
        check("arb_gnt_x3", 32'(gnt_mask), 32'h80);
        dbg_access(1'b0, 9'h020, 8'h00, rd, granted);
        $display("DBG RD {0,1,0,0} data=%02h", rd);
        check("dbg_wr_5a", 32'(rd), 32'h5A);
        instr(2'b00, 4'h0, 2'b01, 4'h4, 4'h0, oe_mask, x2d);
        instr(2'b01, 4'h9, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RDM chip1 char0 data=%h", x2d);
        check("cpu_rd_char0", 32'(x2d), 32'hA);
        instr(2'b00, 4'h0, 2'b01, 4'h4, 4'h1, oe_mask, x2d);
        instr(2'b01, 4'h9, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RDM chip1 char1 data=%h", x2d);
        check("cpu_rd_char1", 32'(x2d), 32'h5);

        // Out-of-range bank: granted, write dropped, read returns 0.
        dbg_access(1'b1, 9'h100, 8'hFF, rd, granted);
        check("oor_wr_gnt", 32'(granted), 32'h1);
        dbg_access(1'b0, 9'h100, 8'h00, rd, granted);
        $display("DBG RD oor data=%02h", rd);
        check("oor_rd_gnt", 32'(granted), 32'h1);
        check("oor_rd_zero", 32'(rd), 32'h00);

        // Reset asserted mid-RDM: dbus_oe must never assert.
        instr(2'b00, 4'h0, 2'b01, 4'h2, 4'h5, oe_mask, x2d);
        oe_any = 1'b0;
        @(negedge clk);
        sync = 1'b1;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            sync    = 1'b0;
            cm_ram  = (p == 4) ? 2'b01 : 2'b00;
            dbus_in = (p == 4) ? 4'h9 : 4'h0;
            #1;
            oe_any = oe_any | dbus_oe;
            if (p == 5) rst = 1'b1;
        end
        repeat (3) begin @(negedge clk); #1; oe_any = oe_any | dbus_oe; end
        rst = 1'b0; cm_ram = '0; dbus_in = '0;
        repeat (10) begin @(negedge clk); #1; oe_any = oe_any | dbus_oe; end
        $display("RST mid-RDM oe_any=%b io_out=%08h", oe_any, io_out);
        check("rst_mid_no_oe", 32'(oe_any), 32'h0);
        check("rst_post_io", io_out, 32'h0);
        check("rst_post_rdata", 32'(dbg_rdata), 32'h0);
        check("rst_post_dbus", 32'(dbus_out), 32'h0);
        dbg_access(1'b0, 9'h012, 8'h00, rd, granted);
        $display("DBG RD after rst data=%02h", rd);
        check("rst_mem_cleared", 32'(rd), 32'h00);

`ifdef I4002_BANK_CLR_EN
        // Clear sweep: fill, sweep, verify memory zero and io_out kept.
        dbg_access(1'b1, 9'h0FF, 8'h3C, rd, granted);
        dbg_access(1'b1, 9'h012, 8'h96, rd, granted);
        instr(2'b00, 4'h0, 2'b01, 4'hD, 4'h0, oe_mask, x2d);
        instr(2'b01, 4'h4, 2'b00, 4'h9, 4'h0, oe_mask, x2d);
        instr(2'b00, 4'h0, 2'b10, 4'h4, 4'h0, oe_mask, x2d);
        instr(2'b10, 4'h1, 2'b00, 4'hE, 4'h0, oe_mask, x2d);
        check("clr_io_before", io_out, 32'h00E0_0000);
        dbg_access(1'b0, 9'h012, 8'h00, rd, granted);
        check("clr_fill_check", 32'(rd), 32'h96);
        @(negedge clk);
        dbg_clr = 1'b1;
        @(negedge clk);
        dbg_clr = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) dbg_clr = 1'b1;
            if (i == 11) dbg_clr = 1'b0;
            if (clr_busy) busy_cnt++;
            @(negedge clk);
        end
        $display("CLR busy_cycles=%0d", busy_cnt);
        check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        dbg_access(1'b0, 9'h0FF, 8'h00, rd, granted);
        check("clr_rd_13_37", 32'(rd), 32'h00);
        dbg_access(1'b0, 9'h012, 8'h00, rd, granted);
        check("clr_rd_00_22", 32'(rd), 32'h00);
        instr(2'b00, 4'h0, 2'b01, 4'hD, 4'h0, oe_mask, x2d);
        instr(2'b01, 4'hC, 2'b00, 4'h0, 4'h0, oe_mask, x2d);
        $display("RD0 after clear data=%h", x2d);
        check("clr_stat_zero", 32'(x2d), 32'h0);
        check("clr_io_kept", io_out, 32'h00E0_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
